mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter sharing one memory port between the instruction fetch path and the load/store data path. It accepts level-held requests from both requesters and grants one transaction at a time. It forwards the transaction to the downstream memory and routes the completion (`ready` plus read data) back to the owning requester only. It sits between `inst_fetch` / the LSU and the unified memory/bus interface.

## Interface
Parameters:
- `STARVE_MAX`, 4: consecutive data grants allowed while an instruction request waits (guard build only).
- `CNT_W`, 3: width of the starvation counter; must satisfy 2^CNT_W > STARVE_MAX.

Ports (widths use the shared `MAX_BIT_POS`, 32-bit datapath). Clock is `clk`. Reset is `rst`, asynchronous, active-low.
- `clk` in 1: clock
- `rst` in 1: async active-low reset
- `i_req` in 1: instruction read request, held until `i_ready`
- `i_addr` in 32: instruction address
- `i_data` out 32: instruction read data
- `i_ready` out 1: instruction completion, one-cycle pulse
- `d_req` in 1: data request, held until `d_ready`
- `d_we` in 1: 1 = write, 0 = read
- `d_addr` in 32: data address
- `d_wdata` in 32: write data
- `d_wstrb` in 4: byte enables for writes
- `d_rdata` out 32: load data
- `d_ready` out 1: data completion, one-cycle pulse
- `m_en` out 1: memory access active
- `m_we` out 1: memory write
- `m_addr` out 32: memory address
- `m_wdata` out 32: memory write data
- `m_wstrb` out 4: memory byte enables
- `m_rdata` in 32: memory read data
- `m_ready` in 1: memory completion, sampled only in a BUSY state

## Operation
- States:
  - IDLE: no transaction outstanding.
  - BUSY_I: instruction transaction in flight.
  - BUSY_D: data transaction in flight.
- IDLE, neither request asserted: stay in IDLE.
- IDLE, only one request asserted: grant that port.
- IDLE, both requests asserted: grant data (fixed priority; see Configuration for the starvation guard).
- On grant, register the command:
  - `m_addr` takes `i_addr` or `d_addr`.
  - For an instruction grant: `m_we=0`, `m_wstrb=0`, `m_wdata=0`.
  - For a data grant: copy `d_we`, `d_wdata`, `d_wstrb`; force `m_wstrb=0` when `d_we=0`.
  - Assert `m_en`; go to BUSY_I or BUSY_D.
- BUSY_x: hold `m_*` stable until `m_ready=1`. On that edge, clear `m_en` and return to IDLE.
- Completion routing is combinational:
  - `i_ready = m_ready & BUSY_I`; `d_ready = m_ready & BUSY_D`.
  - `i_data = m_rdata` and `d_rdata = m_rdata` (passthrough; valid only with the matching ready).
- Request dropped mid-transaction (the requester redirected): the memory access still completes. Ready is masked (`x_ready = m_ready & BUSY_x & x_req`), so there is no ghost completion.
- `m_ready` while in IDLE is ignored.
- Reset values:
  - state = IDLE
  - `m_en=0`, `m_we=0`, `m_addr=0`, `m_wdata=0`, `m_wstrb=0`
  - `i_ready=0`, `d_ready=0`
  - starvation counter = 0

## Timing
- Request seen high in IDLE at cycle t: `m_en=1` with the latched command from cycle t+1.
- `m_ready` may assert in cycle t+1 (zero-wait memory) or any later cycle.
- `x_ready` is high in the same cycle as `m_ready`. The requester updates its request at that edge.
- The arbiter is in IDLE at the next cycle. This gives a minimum of 2 cycles per access and one arbitration per cycle in IDLE.
- There is no back-to-back grant in a completion cycle. One IDLE cycle always separates transactions, which guarantees a held request is never re-granted twice.
- Address, data and requests must be stable while `x_req=1`. Changes during BUSY are not observed.

## Configuration
- Macro: `MEM_ARB_STARVE_GUARD_EN`.
- Defined:
  - The counter increments on each data grant made while `i_req=1`.
  - When counter == `STARVE_MAX` and both requests are high, grant instruction and clear the counter.
  - The counter also clears on any instruction grant, or on an arbitration where `i_req=0`.
  - It saturates at `STARVE_MAX`.
- Undefined: strict data priority. The counter logic is absent and `STARVE_MAX`/`CNT_W` are unused.

## Structure
- The state encodings (`ARB_IDLE`, `ARB_BUSY_I`, `ARB_BUSY_D`) and the 4-bit strobe width belong in the shared `config.v`, alongside `MAX_BIT_POS`.
- One sub-module, `arb_pick`: combinational choice from (`i_req`, `d_req`, starve_hit) producing `grant_i` and `grant_d`. All state and registers stay in `mem_arbiter`.

## Test plan
- Reset, then `i_req=1`, `i_addr=0x100`, memory ready at the 1st BUSY cycle:
  - `m_en=1`, `m_addr=0x100`, `m_we=0` at t+1.
  - `i_ready=1`, `i_data=m_rdata` at t+1; `d_ready=0`.
- `i_req` and `d_req` high together, `d_we=1`, `d_addr=0x2000`, `d_wdata=0xDEADBEEF`, `d_wstrb=0xF`:
  - Data granted first, with `m_we=1` and `m_wstrb=0xF`.
  - Instruction granted after one IDLE cycle.
- Memory latency 3 cycles on a data read:
  - `m_addr` and `m_en` are stable for 3 cycles.
  - `d_ready` pulses exactly once.
  - `i_req` raised mid-transaction waits.
- Both requests held continuously, guard defined, `STARVE_MAX=4`:
  - Grant sequence is D, D, D, D, I, D…
  - Guard undefined: D forever, I never granted.
- `i_req` dropped during BUSY_I: `m_ready` arrives with `i_ready=0`, and the arbiter returns to IDLE.
- `rst` asserted during BUSY_D with `m_ready` arriving after release:
  - All outputs are zero immediately.
  - The late `m_ready` produces no `d_ready`.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the instruction/data memory arbiter: datapath
//   bit position, byte-strobe width and the arbiter state encodings.
//   Optional build macro used by the arbiter: MEM_ARB_STARVE_GUARD_EN.
package mem_arbiter_pkg;

  localparam int MAX_BIT_POS = 31;   // 32-bit datapath, MSB index
  localparam int STRB_W      = 4;    // byte enables per word

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick
//   Combinational grant choice for the memory arbiter. Data has fixed
//   priority unless the starvation guard reports a hit while an instruction
//   request is waiting, in which case the instruction port wins.
// Ports:
//   i_req, d_req  - level requests from the instruction and data paths
//   starve_hit    - starvation limit reached (tied low when guard absent)
//   grant_i       - grant the instruction port this arbitration
//   grant_d       - grant the data port this arbitration
module arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic starve_hit,
  output logic grant_i,
  output logic grant_d
);

  assign grant_d = d_req & ~(i_req & starve_hit);
  assign grant_i = i_req & ~grant_d;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one memory port between instruction fetch and the load/store
//   path. One transaction in flight at a time; the memory command is
//   registered at grant and held until m_ready. Completions are routed
//   combinationally to the owning requester and masked if it has dropped
//   its request (redirect), so there is never a ghost completion.
//   Build macro MEM_ARB_STARVE_GUARD_EN: when defined, after STARVE_MAX
//   consecutive data grants with an instruction request waiting, the
//   instruction port is granted once. When undefined, data has strict
//   priority and STARVE_MAX/CNT_W only feed the configuration check.
// Ports:
//   clk, rst                     - clock, async active-low reset
//   i_req/i_addr/i_data/i_ready  - instruction read port
//   d_req/d_we/d_addr/d_wdata/d_wstrb/d_rdata/d_ready - data port
//   m_en/m_we/m_addr/m_wdata/m_wstrb/m_rdata/m_ready  - memory port
//
// state      | meaning
// ARB_IDLE   | no transaction outstanding, arbitrate every cycle
// ARB_BUSY_I | instruction fetch in flight, waiting for m_ready
// ARB_BUSY_D | data access in flight, waiting for m_ready
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [MAX_BIT_POS:0]  i_addr,
  output logic [MAX_BIT_POS:0]  i_data,
  output logic                  i_ready,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [MAX_BIT_POS:0]  d_addr,
  input  logic [MAX_BIT_POS:0]  d_wdata,
  input  logic [STRB_W-1:0]     d_wstrb,
  output logic [MAX_BIT_POS:0]  d_rdata,
  output logic                  d_ready,
  output logic                  m_en,
  output logic                  m_we,
  output logic [MAX_BIT_POS:0]  m_addr,
  output logic [MAX_BIT_POS:0]  m_wdata,
  output logic [STRB_W-1:0]     m_wstrb,
  input  logic [MAX_BIT_POS:0]  m_rdata,
  input  logic                  m_ready
);

  // The counter must be able to hold STARVE_MAX.
  if ((1 << CNT_W) <= STARVE_MAX) begin : g_bad_starve_cfg
    $error("mem_arbiter: 2**CNT_W must exceed STARVE_MAX");
  end

  arb_state_e state;
  logic       starve_hit;
  logic       grant_i;
  logic       grant_d;

  arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .starve_hit (starve_hit),
    .grant_i    (grant_i),
    .grant_d    (grant_d)
  );

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [CNT_W-1:0] starve_cnt;

  assign starve_hit = (starve_cnt == CNT_W'(STARVE_MAX));

  // Counts data grants that overtook a waiting instruction request. Only
  // arbitrations (IDLE cycles) touch it; it saturates at STARVE_MAX.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (state == ARB_IDLE) begin
      if (!i_req || grant_i) begin
        starve_cnt <= '0;
      end else if (grant_d && !starve_hit) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
`else
  assign starve_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ARB_IDLE;
      m_en    <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_wstrb <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_d) begin
            state   <= ARB_BUSY_D;
            m_en    <= 1'b1;
            m_we    <= d_we;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            m_wstrb <= d_we ? d_wstrb : '0;
          end else if (grant_i) begin
            state   <= ARB_BUSY_I;
            m_en    <= 1'b1;
            m_we    <= 1'b0;
            m_addr  <= i_addr;
            m_wdata <= '0;
            m_wstrb <= '0;
          end
        end
        // No re-grant on the completion edge: one IDLE cycle always
        // separates transactions so a held request is never double-served.
        ARB_BUSY_I, ARB_BUSY_D: begin
          if (m_ready) begin
            state <= ARB_IDLE;
            m_en  <= 1'b0;
          end
        end
        default: begin
          state <= ARB_IDLE;
          m_en  <= 1'b0;
        end
      endcase
    end
  end

  // Masking with the live request suppresses completions of redirected
  // accesses; m_ready in IDLE falls out as ignored.
  assign i_ready = m_ready & (state == ARB_BUSY_I) & i_req;
  assign d_ready = m_ready & (state == ARB_BUSY_D) & d_req;
  assign i_data  = m_rdata;
  assign d_rdata = m_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Randomized requesters and memory around mem_arbiter. A reference model
//   predicts grants (by the arbitration rules) and completions, pushing
//   them into queues; a monitor pops and compares whenever the DUT starts a
//   memory access or presents a ready. Honors MEM_ARB_STARVE_GUARD_EN.
module tb_mem_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we, m_ready;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [3:0]  d_wstrb;
  logic [31:0] i_data, d_rdata, m_addr, m_wdata;
  logic        i_ready, d_ready, m_en, m_we;
  logic [3:0]  m_wstrb;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_MAX(STARVE_MAX), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_data(i_data), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_rdata(d_rdata), .d_ready(d_ready),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_rdata(m_rdata), .m_ready(m_ready)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } cmd_t;

  typedef struct {
    logic        port_d;
    logic [31:0] data;
  } cpl_t;

  cmd_t cmd_q[$];
  cpl_t cpl_q[$];
  bit   grant_log[$];   // 1 = data grant, 0 = instruction grant

  int checks = 0;
  int errors = 0;

  // model state: owner of the memory (0 none, 1 instr, 2 data)
  int own = 0;
  int lat = 0;
  int streak = 0;
  int lat_max = 3;
  bit gen_en = 0, hold_mode = 0, drop_en = 0, mon_en = 0, log_en = 0;
  bit exp_m_en = 0;
  bit done_i, done_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus and prediction.
  task automatic step();
    bit done;
    int win;
    @(negedge clk);
    exp_m_en = (own != 0);
    done = 0;
    m_ready = 1'b0;
    if (own != 0) begin
      if (lat == 0) begin
        done = 1;
        m_ready = 1'b1;
      end else begin
        lat--;
      end
    end else begin
      m_ready = ($urandom_range(0, 3) == 0);   // stray ready while idle
    end
    m_rdata = $urandom;
    done_i = done && own == 1;
    done_d = done && own == 2;
    if (done_i && i_req) cpl_q.push_back('{1'b0, m_rdata});
    if (done_d && d_req) cpl_q.push_back('{1'b1, m_rdata});

    if (own == 0) begin
      win = 0;
`ifdef MEM_ARB_STARVE_GUARD_EN
      if (i_req && d_req && streak == STARVE_MAX) win = 1;
      else if (d_req) win = 2;
      else if (i_req) win = 1;
      if (win == 1 || !i_req) streak = 0;
      else if (win == 2 && streak < STARVE_MAX) streak++;
`else
      if (d_req) win = 2;
      else if (i_req) win = 1;
`endif
      if (win == 1) cmd_q.push_back('{i_addr, 1'b0, 32'h0, 4'h0});
      if (win == 2) cmd_q.push_back('{d_addr, d_we, d_wdata, d_we ? d_wstrb : 4'h0});
      own = win;
      lat = $urandom_range(0, lat_max);
    end else if (done) begin
      own = 0;
    end

    // requesters react just after the clock edge
    @(posedge clk);
    #1;
    if (done_i) i_req = 1'b0;
    if (done_d) d_req = 1'b0;
    if (own == 1 && i_req && drop_en && $urandom_range(0, 5) == 0) i_req = 1'b0;
    if (own == 2 && d_req && drop_en && $urandom_range(0, 5) == 0) d_req = 1'b0;
    if (!i_req && own != 1 && gen_en && (hold_mode || $urandom_range(0, 2) == 0)) begin
      i_req  = 1'b1;
      i_addr = $urandom & 32'h7FFF_FFFC;
    end
    if (!d_req && own != 2 && gen_en && (hold_mode || $urandom_range(0, 2) == 0)) begin
      d_req   = 1'b1;
      d_we    = 1'($urandom_range(0, 1));
      d_addr  = $urandom | 32'h8000_0000;
      d_wdata = $urandom;
      d_wstrb = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic drain();
    int n = 0;
    gen_en = 0;
    drop_en = 0;
    hold_mode = 0;
    while ((own != 0 || i_req || d_req) && n < 60) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(n < 60), 32'd1);
    step();
    step();
  endtask

  // monitor / scoreboard
  initial begin
    cmd_t cur;
    cpl_t p;
    bit   prev_en = 0;
    cur = '{32'h0, 1'b0, 32'h0, 4'h0};
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        chk("m_en", 32'(m_en), 32'(exp_m_en));
        if (m_en && !prev_en) begin
          if (cmd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL grant: unexpected access addr %h", m_addr);
          end else begin
            cur = cmd_q.pop_front();
            if (log_en) grant_log.push_back(m_addr[31]);
          end
        end
        if (m_en) begin
          chk("m_addr", m_addr, cur.addr);
          chk("m_we", 32'(m_we), 32'(cur.we));
          chk("m_wdata", m_wdata, cur.wdata);
          chk("m_wstrb", 32'(m_wstrb), 32'(cur.wstrb));
        end
        if (i_ready || d_ready) begin
          if (cpl_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL ghost_ready: i_ready %b d_ready %b with none expected", i_ready, d_ready);
          end else begin
            p = cpl_q.pop_front();
            chk("both_ready", 32'(i_ready & d_ready), 32'd0);
            chk("ready_port", 32'(d_ready), 32'(p.port_d));
            chk("rdata", d_ready ? d_rdata : i_data, p.data);
          end
        end
        chk("missing_ready", 32'(cpl_q.size()), 32'd0);
        cpl_q.delete();
      end
      prev_en = m_en;
    end
  end

  initial begin
    rst = 1'b0;
    i_req = 0; d_req = 0; d_we = 0; m_ready = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0; m_rdata = 0;
    #1;
    chk("rst_m_en", 32'(m_en), 0);
    chk("rst_m_we", 32'(m_we), 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_m_wstrb", 32'(m_wstrb), 0);
    chk("rst_i_ready", 32'(i_ready), 0);
    chk("rst_d_ready", 32'(d_ready), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    mon_en = 1;

    // random traffic with redirects and variable memory latency
    gen_en = 1; drop_en = 1; lat_max = 3;
    repeat (600) step();
    drain();

    // both requests held continuously
    log_en = 1; gen_en = 1; hold_mode = 1; lat_max = 2;
    repeat (40) step();
    drain();
    log_en = 0;
    chk("hold_grants", 32'(grant_log.size() >= 10), 1);
    if (grant_log.size() >= 10) begin
      for (int k = 0; k < 10; k++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
        chk($sformatf("hold_seq[%0d]", k), 32'(grant_log[k]), 32'((k % 5) != 4));
`else
        chk($sformatf("hold_seq[%0d]", k), 32'(grant_log[k]), 32'd1);
`endif
      end
    end

    // reset while a data write is in flight
    d_req = 1; d_we = 1; d_addr = 32'h8000_2000; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hA;
    step();
    lat = 6;
    step();
    #2;
    mon_en = 0;
    m_ready = 1'b1;
    rst = 1'b0;
    #1;
    chk("arst_m_en", 32'(m_en), 0);
    chk("arst_m_we", 32'(m_we), 0);
    chk("arst_m_addr", m_addr, 0);
    chk("arst_m_wdata", m_wdata, 0);
    chk("arst_m_wstrb", 32'(m_wstrb), 0);
    chk("arst_d_ready", 32'(d_ready), 0);
    chk("arst_i_ready", 32'(i_ready), 0);
    @(negedge clk);
    rst = 1'b1;
    m_ready = 1'b1;
    #1;
    chk("late_d_ready", 32'(d_ready), 0);
    chk("late_i_ready", 32'(i_ready), 0);
    d_req = 0;
    m_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_m_en", 32'(m_en), 0);
    own = 0; streak = 0; exp_m_en = 0;
    cmd_q.delete();
    mon_en = 1;

    // traffic after reset
    gen_en = 1; drop_en = 1; lat_max = 3;
    repeat (150) step();
    drain();
    chk("cmd_q_left", 32'(cmd_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
